// File: rtl/alu_scheduler.sv
// alu_scheduler: two-requester front end for one shared ALU (IDLE/EXEC/RESP).
// Define ALU_SCHED_ROUND_ROBIN_EN for round-robin arbitration; default is fixed priority.
package alu_pkg;
  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4
  } alu_func_e;
endpackage

module alu_scheduler
  import alu_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [2:0]        req0_func,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [2:0]        req1_func,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_zero,
  output logic              rsp_positive,
  output logic              rsp_carry,
  output logic              rsp_overflow,
  output logic              rsp_error,
  output logic [DATA_W-1:0] alu_operand_a,
  output logic [DATA_W-1:0] alu_operand_b,
  output logic [2:0]        alu_func,
  output logic              alu_output_enable,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  input  logic              alu_positive,
  input  logic              alu_carry,
  input  logic              alu_overflow
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [2:0]        func_q;
  logic [DATA_W-1:0] a_q, b_q;
  logic              id_q;
  logic              idle, exec;
  logic              gnt1, hs;
  logic              func_ok, addsub;

  logic              rsp_id_q;
  logic [DATA_W-1:0] res_q;
  logic              zero_q, pos_q;
  logic              carry_q, ovf_q, err_q;

  assign idle = (state_q == S_IDLE) && !rst;
  assign exec = (state_q == S_EXEC);

`ifdef ALU_SCHED_ROUND_ROBIN_EN
  logic last_q;

  // Tie goes to the requester that did not win last time.
  assign gnt1 = req1_valid & (!req0_valid | !last_q);

  // Remember who won the most recent handshake.
  always_ff @(posedge clk) begin
    if (rst)     last_q <= 1'b1;
    else if (hs) last_q <= gnt1;
  end
`else
  assign gnt1 = req1_valid & !req0_valid;
`endif

  assign req0_ready = idle & req0_valid & !gnt1;
  assign req1_ready = idle & gnt1;
  assign hs = (req0_valid & req0_ready)
            | (req1_valid & req1_ready);

  assign func_ok = func_q inside
    {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR};
  assign addsub = (func_q == ALU_ADD)
               || (func_q == ALU_SUB);

  // Next-state: one EXEC cycle, RESP held until consumed.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (hs) state_d = S_EXEC;
      S_EXEC:  state_d = S_RESP;
      S_RESP:  if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register; reset aborts any in-flight op.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Latch the granted request's payload at handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      func_q <= '0;
      a_q    <= '0;
      b_q    <= '0;
      id_q   <= 1'b0;
    end else if (hs) begin
      func_q <= gnt1 ? req1_func : req0_func;
      a_q    <= gnt1 ? req1_a : req0_a;
      b_q    <= gnt1 ? req1_b : req0_b;
      id_q   <= gnt1;
    end
  end

  // Capture ALU outputs at the end of EXEC; mask X-prone flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_id_q <= 1'b0;
      res_q    <= '0;
      zero_q   <= 1'b0;
      pos_q    <= 1'b0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
    end else if (exec) begin
      rsp_id_q <= id_q;
      if (func_ok) begin
        res_q   <= alu_result;
        zero_q  <= alu_zero;
        pos_q   <= alu_positive;
        carry_q <= addsub & alu_carry;
        ovf_q   <= addsub & alu_overflow;
        err_q   <= 1'b0;
      end else begin
        res_q   <= '0;
        zero_q  <= 1'b0;
        pos_q   <= 1'b0;
        carry_q <= 1'b0;
        ovf_q   <= 1'b0;
        err_q   <= 1'b1;
      end
    end
  end

  assign alu_operand_a     = exec ? a_q : '0;
  assign alu_operand_b     = exec ? b_q : '0;
  assign alu_func          = exec ? func_q : 3'd0;
  assign alu_output_enable = exec & func_ok;

  assign rsp_valid    = (state_q == S_RESP);
  assign rsp_id       = rsp_id_q;
  assign rsp_result   = res_q;
  assign rsp_zero     = zero_q;
  assign rsp_positive = pos_q;
  assign rsp_carry    = carry_q;
  assign rsp_overflow = ovf_q;
  assign rsp_error    = err_q;

endmodule

// File: tb/tb_alu_scheduler.sv
// tb_alu_scheduler: directed vectors for alu_scheduler with a behavioural ALU.
// Expectations follow ALU_SCHED_ROUND_ROBIN_EN when it is defined.
module tb_alu_scheduler;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req1_valid;
  logic       req0_ready, req1_ready;
  logic [2:0] req0_func, req1_func;
  logic [7:0] req0_a, req0_b, req1_a, req1_b;
  logic       rsp_valid, rsp_ready, rsp_id;
  logic [7:0] rsp_result;
  logic       rsp_zero, rsp_positive;
  logic       rsp_carry, rsp_overflow, rsp_error;
  logic [7:0] alu_operand_a, alu_operand_b;
  logic [2:0] alu_func;
  logic       alu_output_enable;
  logic [7:0] alu_result;
  logic       alu_zero, alu_positive;
  logic       alu_carry, alu_overflow;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_scheduler #(.DATA_W(8)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_func(req0_func), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_func(req1_func), .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_zero(rsp_zero), .rsp_positive(rsp_positive),
    .rsp_carry(rsp_carry), .rsp_overflow(rsp_overflow),
    .rsp_error(rsp_error),
    .alu_operand_a(alu_operand_a), .alu_operand_b(alu_operand_b),
    .alu_func(alu_func), .alu_output_enable(alu_output_enable),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .alu_positive(alu_positive), .alu_carry(alu_carry),
    .alu_overflow(alu_overflow)
  );

  // Shared ALU model: junk outputs when disabled, carry/overflow
  // forced high on logic ops to stand in for X.
  logic [7:0] m_r;
  logic       m_c, m_v;
  always_comb begin
    m_r = 8'hA5;
    m_c = 1'b1;
    m_v = 1'b1;
    if (alu_output_enable) begin
      case (alu_func)
        ALU_ADD: begin
          {m_c, m_r} = {1'b0, alu_operand_a} + {1'b0, alu_operand_b};
          m_v = (alu_operand_a[7] == alu_operand_b[7])
             && (m_r[7] != alu_operand_a[7]);
        end
        ALU_SUB: begin
          {m_c, m_r} = {1'b0, alu_operand_a} - {1'b0, alu_operand_b};
          m_v = (alu_operand_a[7] != alu_operand_b[7])
             && (m_r[7] != alu_operand_a[7]);
        end
        ALU_AND: m_r = alu_operand_a & alu_operand_b;
        ALU_OR:  m_r = alu_operand_a | alu_operand_b;
        ALU_XOR: m_r = alu_operand_a ^ alu_operand_b;
        default: m_r = 8'hA5;
      endcase
    end
  end
  assign alu_result   = m_r;
  assign alu_zero     = alu_output_enable ? (m_r == 8'h00) : 1'b1;
  assign alu_positive = alu_output_enable ? !m_r[7] : 1'b1;
  assign alu_carry    = m_c;
  assign alu_overflow = m_v;

  typedef struct {
    logic       id;
    logic [2:0] f;
    logic [7:0] a, b, r;
    logic       z, p, c, v, e;
  } vec_t;

  vec_t tv[8];
  logic exp_ids[4];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Issue one op from requester id, leave bench at the first RESP negedge.
  task automatic run_op(input logic id, input logic [2:0] f,
                        input logic [7:0] a, input logic [7:0] b,
                        input logic e);
    if (id) begin
      req1_valid = 1'b1; req1_func = f; req1_a = a; req1_b = b;
    end else begin
      req0_valid = 1'b1; req0_func = f; req0_a = a; req0_b = b;
    end
    #1;
    chk("grant0", {31'd0, req0_ready}, {31'd0, !id});
    chk("grant1", {31'd0, req1_ready}, {31'd0, id});
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk("exec_oe", {31'd0, alu_output_enable}, {31'd0, !e});
    chk("exec_opa", {24'd0, alu_operand_a}, {24'd0, a});
    chk("exec_opb", {24'd0, alu_operand_b}, {24'd0, b});
    chk("exec_func", {29'd0, alu_func}, {29'd0, f});
    chk("exec_rspv", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    chk("resp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("resp_oe", {31'd0, alu_output_enable}, 32'd0);
    chk("resp_opa", {24'd0, alu_operand_a}, 32'd0);
  endtask

  task automatic finish_rsp();
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_done", {31'd0, rsp_valid}, 32'd0);
  endtask

  initial begin
    int k;
    tv[0] = '{1'b0, ALU_ADD, 8'h7F, 8'h01, 8'h80, 0, 0, 0, 1, 0};
    tv[1] = '{1'b1, ALU_AND, 8'hF0, 8'h0F, 8'h00, 1, 1, 0, 0, 0};
    tv[2] = '{1'b0, ALU_OR,  8'h12, 8'h34, 8'h36, 0, 1, 0, 0, 0};
    tv[3] = '{1'b1, ALU_XOR, 8'hFF, 8'h0F, 8'hF0, 0, 0, 0, 0, 0};
    tv[4] = '{1'b0, ALU_ADD, 8'hFF, 8'h01, 8'h00, 1, 1, 1, 0, 0};
    tv[5] = '{1'b1, ALU_SUB, 8'h80, 8'h01, 8'h7F, 0, 1, 0, 1, 0};
    tv[6] = '{1'b0, 3'd7,    8'h01, 8'h01, 8'h00, 0, 0, 0, 0, 1};
    tv[7] = '{1'b1, 3'd5,    8'h22, 8'h33, 8'h00, 0, 0, 0, 0, 1};
`ifdef ALU_SCHED_ROUND_ROBIN_EN
    exp_ids = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
    exp_ids = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif

    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
    req0_func = '0; req0_a = '0; req0_b = '0;
    req1_func = '0; req1_a = '0; req1_b = '0;

    // Reset state, and no ready while reset is high.
    repeat (2) @(negedge clk);
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    chk("rst_rdy0", {31'd0, req0_ready}, 32'd0);
    chk("rst_rdy1", {31'd0, req1_ready}, 32'd0);
    chk("rst_rspv", {31'd0, rsp_valid}, 32'd0);
    chk("rst_id", {31'd0, rsp_id}, 32'd0);
    chk("rst_res", {24'd0, rsp_result}, 32'd0);
    chk("rst_flags", {27'd0, rsp_zero, rsp_positive, rsp_carry,
                      rsp_overflow, rsp_error}, 32'd0);
    chk("rst_oe", {31'd0, alu_output_enable}, 32'd0);
    chk("rst_drv", {13'd0, alu_operand_a, alu_operand_b, alu_func},
        32'd0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Contention: both requesters held valid for four ops.
    req0_valid = 1'b1; req0_func = ALU_ADD; req0_a = 8'h01; req0_b = 8'h01;
    req1_valid = 1'b1; req1_func = ALU_ADD; req1_a = 8'h02; req1_b = 8'h02;
    for (int i = 0; i < 4; i++) begin
      k = 0;
      while (!rsp_valid && k < 10) begin
        @(negedge clk);
        k++;
      end
      chk("cont_timeout", {31'd0, rsp_valid}, 32'd1);
      chk("cont_id", {31'd0, rsp_id}, {31'd0, exp_ids[i]});
      chk("cont_res", {24'd0, rsp_result},
          exp_ids[i] ? 32'h04 : 32'h02);
      finish_rsp();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);

    // Single-requester vectors.
    for (int i = 0; i < 8; i++) begin
      run_op(tv[i].id, tv[i].f, tv[i].a, tv[i].b, tv[i].e);
      chk("v_id", {31'd0, rsp_id}, {31'd0, tv[i].id});
      chk("v_res", {24'd0, rsp_result}, {24'd0, tv[i].r});
      chk("v_zero", {31'd0, rsp_zero}, {31'd0, tv[i].z});
      chk("v_pos", {31'd0, rsp_positive}, {31'd0, tv[i].p});
      chk("v_carry", {31'd0, rsp_carry}, {31'd0, tv[i].c});
      chk("v_ovf", {31'd0, rsp_overflow}, {31'd0, tv[i].v});
      chk("v_err", {31'd0, rsp_error}, {31'd0, tv[i].e});
      finish_rsp();
    end

    // Backpressure, with a request arriving during RESP.
    run_op(1'b0, ALU_SUB, 8'h00, 8'h01, 1'b0);
    req1_valid = 1'b1; req1_func = ALU_ADD; req1_a = 8'h01; req1_b = 8'h01;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("bp_res", {24'd0, rsp_result}, 32'hFF);
      chk("bp_carry", {31'd0, rsp_carry}, 32'd1);
      chk("bp_pos", {31'd0, rsp_positive}, 32'd0);
      chk("bp_rdy", {30'd0, req0_ready, req1_ready}, 32'd0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1;
    chk("bypass_rdy", {30'd0, req0_ready, req1_ready}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("bp_drop", {31'd0, rsp_valid}, 32'd0);
    chk("bp_wait_rdy", {31'd0, req1_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    req1_valid = 1'b0;
    chk("bp_exec_oe", {31'd0, alu_output_enable}, 32'd1);
    @(negedge clk);
    chk("bp2_valid", {31'd0, rsp_valid}, 32'd1);
    chk("bp2_id", {31'd0, rsp_id}, 32'd1);
    chk("bp2_res", {24'd0, rsp_result}, 32'h02);
    finish_rsp();

    // Reset during EXEC drops the op.
    req0_valid = 1'b1; req0_func = ALU_ADD; req0_a = 8'h7F; req0_b = 8'h01;
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b0;
    chk("mid_oe", {31'd0, alu_output_enable}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rspv", {31'd0, rsp_valid}, 32'd0);
    chk("mid_oe0", {31'd0, alu_output_enable}, 32'd0);
    chk("mid_opa", {24'd0, alu_operand_a}, 32'd0);
    req0_valid = 1'b1;
    #1;
    chk("mid_rst_rdy", {31'd0, req0_ready}, 32'd0);
    req0_valid = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mid_no_rsp", {31'd0, rsp_valid}, 32'd0);
    end
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    chk("post_rst_rdy", {30'd0, req0_ready, req1_ready}, 32'd2);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_scheduler.md
ALU_SCHEDULER -- requirements
Module: alu_scheduler

Interface
REQ-001 Parameter: DATA_W, default 8, operand/result width; SHALL match the shared alu instance.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req0_valid / req1_valid  input  1 each  requester N has an operation pending.
REQ-005 req0_ready / req1_ready  output  1 each  operation from requester N accepted this cycle.
REQ-006 req0_func / req1_func  input  3 each  alu_func_e code (alu_pkg).
REQ-007 req0_a, req0_b / req1_a, req1_b  input  DATA_W each  operands.
REQ-008 rsp_valid  output  1  response held for the requester.
REQ-009 rsp_ready  input  1  response consumer accepts.
REQ-010 rsp_id  output  1  requester index owning the response.
REQ-011 rsp_result  output  DATA_W  captured ALU result.
REQ-012 rsp_zero, rsp_positive, rsp_carry, rsp_overflow  output  1 each  captured flags.
REQ-013 rsp_error  output  1  func code not a defined alu_func_e member.
REQ-014 alu_operand_a, alu_operand_b  output  DATA_W  drive ALU operand inputs.
REQ-015 alu_func  output  3  drives ALU function select.
REQ-016 alu_output_enable  output  1  drives ALU output_enable.
REQ-017 alu_result  input  DATA_W  ALU result bus.
REQ-018 alu_zero, alu_positive, alu_carry, alu_overflow  input  1 each  ALU flags.

Function
REQ-019 FSM states SHALL be IDLE, EXEC, RESP; state encoding is internal.
REQ-020 IDLE: if any reqN_valid, SHALL assert exactly one reqN_ready combinationally for the granted requester; handshake completes when valid&ready at a rising edge.
REQ-021 Requesters hold valid and payload stable until ready; the block never asserts ready outside IDLE.
REQ-022 On handshake the block SHALL register func/a/b and the grant index, and go to EXEC.
REQ-023 EXEC lasts exactly one cycle: alu_operand_a/b/func driven from registers, alu_output_enable=1; at the end of EXEC, alu_result and flags SHALL be captured into rsp_* registers; next state RESP.
REQ-024 Outside EXEC, alu_output_enable SHALL be 0 and alu_operand_a/b/func SHALL be 0.
REQ-025 RESP: rsp_valid=1 and all rsp_* stable until rsp_valid&rsp_ready; then IDLE. Latency handshake->rsp_valid = 2 cycles; max throughput 1 op per 3 cycles.
REQ-026 rsp_carry and rsp_overflow SHALL be captured as 0 unless func is ADD or SUB (ALU drives X for these).
REQ-027 Undefined func: EXEC still runs with alu_output_enable=0; rsp_result=0, all flags 0, rsp_error=1. Otherwise rsp_error=0.
REQ-028 Arbitration occurs only in IDLE; a request that appears during EXEC/RESP waits, no request is dropped.
REQ-029 Response bypass prohibited: a new handshake SHALL NOT occur in the same cycle as rsp_valid&rsp_ready (IDLE only next cycle).

Reset
REQ-030 rst high at a rising edge SHALL force IDLE from any state, aborting any in-flight op without response.
REQ-031 Reset values: rsp_valid=0, rsp_id=0, rsp_result=0, all rsp flags 0, rsp_error=0, alu_output_enable=0, ALU drive outputs 0, last-grant pointer=1 (so requester 0 wins first).
REQ-032 While rst is high, req0_ready and req1_ready SHALL be 0.

Configuration
REQ-033 Macro ALU_SCHED_ROUND_ROBIN_EN defined: with both valid in IDLE, grant the requester not granted last; last-grant pointer updates on each handshake.
REQ-034 Macro undefined: fixed priority, requester 0 always wins simultaneous requests; pointer logic absent.

Verification
REQ-035 Single op: req0 ADD a=8'h7F b=8'h01 -> EXEC drives OE=1 one cycle; 2 cycles later rsp_valid, id=0, result=8'h80, zero=0, positive=0, carry=0, overflow=1.
REQ-036 Logic op: req1 AND a=8'hF0 b=8'h0F -> result=8'h00, zero=1, positive=1, carry=0, overflow=0, id=1.
REQ-037 Backpressure: SUB a=8'h00 b=8'h01, rsp_ready low 5 cycles -> rsp held: result=8'hFF, carry=1, positive=0; both req*_ready stay 0 throughout.
REQ-038 Contention: both valid continuously, 4 ops -> grant order 0,1,0,1 with macro; 0,0,0,0 without.
REQ-039 Reset mid-op: rst asserted during EXEC -> next cycle IDLE, rsp_valid=0, OE=0; no response emitted for that op.
REQ-040 Undefined func code -> rsp_error=1, result=0, OE never asserted.
